// File: rtl/matrix_frame_buffer.sv
// Ping-pong DIM x DIM matrix collector: one bank fills by (row,col)
// while the other streams out as packed lines under valid/ready.
module matrix_frame_buffer #(
  parameter int DIM    = 32,
  parameter int ELEM_W = 8,
  parameter int ADDR_W = $clog2(DIM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_data_in,
  input  logic [ADDR_W-1:0]     row_addr,
  input  logic [ADDR_W-1:0]     col_addr,
  input  logic [ELEM_W-1:0]     matrix_element,
  input  logic                  transpose_in,
  output logic                  write_ready,
  output logic [DIM*ELEM_W-1:0] line_data,
  output logic [ADDR_W-1:0]     line_index,
  output logic                  valid_data_out,
  input  logic                  ready_in,
  output logic                  frame_last,
  output logic                  dup_err,
  output logic                  ovf_err
);

  localparam int LW = DIM * ELEM_W;
  localparam int CW = $clog2(DIM * DIM + 1);
  localparam int KW = ADDR_W + 1;
  localparam logic [CW-1:0] NFULL = CW'(DIM * DIM);
  localparam logic [KW-1:0] NLINE = KW'(DIM);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bst_e;

  logic [ELEM_W-1:0]       mem_q [2][DIM][DIM];
  logic [DIM-1:0][DIM-1:0] bm_q [2];
  logic [CW-1:0]           cnt_q [2];
  bst_e                    st_q [2];
  bst_e                    st_d [2];
  logic [1:0]              tr_q;
  logic                    wb_q, wb_d;
  logic                    rb_q, rb_d;
  logic                    busy_q, busy_d;
  logic [KW-1:0]           k_q, k_d;
  logic [LW-1:0]           line_q;
  logic [ADDR_W-1:0]       idx_q;
  logic                    last_q, vout_q, dup_q, ovf_q;

  logic              in_rng, wr_ok, acc, seen, done;
  logic              hs_last, start, load, wb_full, oth_ok;
  logic [1:0]        free;
  logic [ADDR_W-1:0] kk;
  logic [LW-1:0]     pack;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]  <= EMPTY;
        bm_q[b]  <= '0;
        cnt_q[b] <= '0;
      end
      tr_q   <= '0;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      busy_q <= 1'b0;
      k_q    <= '0;
      line_q <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
      vout_q <= 1'b0;
      dup_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      busy_q <= busy_d;
      k_q    <= k_d;
      dup_q  <= seen;
      ovf_q  <= valid_data_in && !acc;
      if (acc && !seen) begin
        bm_q[wb_q][row_addr][col_addr] <= 1'b1;
        cnt_q[wb_q] <= cnt_q[wb_q] + CW'(1);
      end
      if (done) tr_q[wb_q] <= transpose_in;
      for (int b = 0; b < 2; b++) begin
        if (free[b]) begin
          bm_q[b]  <= '0;
          cnt_q[b] <= '0;
        end
      end
      if (load) begin
        line_q <= pack;
        idx_q  <= kk;
        last_q <= (k_q == NLINE - KW'(1));
        vout_q <= 1'b1;
      end else if (vout_q && ready_in) begin
        vout_q <= 1'b0;
      end
    end
  end

  // Element storage carries no reset; the bitmap alone defines validity.
  always_ff @(posedge clk) begin
    if (!rst && acc) mem_q[wb_q][row_addr][col_addr] <= matrix_element;
  end

  always_comb begin
    in_rng  = (int'(row_addr) < DIM) && (int'(col_addr) < DIM);
    wr_ok   = (st_q[wb_q] == EMPTY) || (st_q[wb_q] == FILLING);
    acc     = valid_data_in && wr_ok && in_rng;
    seen    = acc && bm_q[wb_q][row_addr][col_addr];
    done    = acc && !seen && ((cnt_q[wb_q] + CW'(1)) == NFULL);
    hs_last = vout_q && ready_in && last_q;
    free    = '0;
    if (hs_last) free[rb_q] = 1'b1;
    rb_d    = hs_last ? ~rb_q : rb_q;
    start   = (!busy_q || hs_last) && (st_q[rb_d] == FULL);
    busy_d  = start || (busy_q && !hs_last);
    load    = busy_q && (k_q != NLINE) && (!vout_q || ready_in);
    k_d     = start ? '0 : (load ? k_q + KW'(1) : k_q);
    // Fill pointer moves off a full bank as soon as the other is free.
    wb_full = done || (st_q[wb_q] == FULL) || (st_q[wb_q] == DRAINING);
    oth_ok  = (st_q[~wb_q] == EMPTY) || free[~wb_q];
    wb_d    = (wb_full && oth_ok) ? ~wb_q : wb_q;
    st_d    = st_q;
    for (int b = 0; b < 2; b++) begin
      if (free[b]) st_d[b] = EMPTY;
    end
    if (start) st_d[rb_d] = DRAINING;
    if (acc) st_d[wb_q] = done ? FULL : FILLING;
  end

  always_comb begin
    kk   = k_q[ADDR_W-1:0];
    pack = '0;
    for (int i = 0; i < DIM; i++) begin
      pack[i*ELEM_W +: ELEM_W] = tr_q[rb_q] ? mem_q[rb_q][i][kk]
                                            : mem_q[rb_q][kk][i];
    end
  end

  always_comb begin
    write_ready    = !rst && wr_ok;
    line_data      = line_q;
    line_index     = idx_q;
    valid_data_out = vout_q;
    frame_last     = last_q;
    dup_err        = dup_q;
    ovf_err        = ovf_q;
  end

endmodule

// File: tb/tb_matrix_frame_buffer.sv
// Directed bench for matrix_frame_buffer at DIM=32, ELEM_W=8.
// Element (r,c) = (7r+c+seed) mod 256 unless overridden.
module tb_matrix_frame_buffer;
  localparam int DIM = 32;
  localparam int EW  = 8;
  localparam int AW  = 5;
  localparam int LW  = DIM * EW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_data_in = 1'b0;
  logic [AW-1:0] row_addr = '0;
  logic [AW-1:0] col_addr = '0;
  logic [EW-1:0] matrix_element = '0;
  logic          transpose_in = 1'b0;
  logic          ready_in = 1'b0;
  logic          write_ready, valid_data_out, frame_last, dup_err, ovf_err;
  logic [LW-1:0] line_data;
  logic [AW-1:0] line_index;

  int checks = 0;
  int errors = 0;

  matrix_frame_buffer #(.DIM(DIM), .ELEM_W(EW)) dut (
    .clk(clk), .rst(rst), .valid_data_in(valid_data_in),
    .row_addr(row_addr), .col_addr(col_addr),
    .matrix_element(matrix_element), .transpose_in(transpose_in),
    .write_ready(write_ready), .line_data(line_data),
    .line_index(line_index), .valid_data_out(valid_data_out),
    .ready_in(ready_in), .frame_last(frame_last),
    .dup_err(dup_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs,
                     input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int fval(input int r, input int c, input int s);
    return (7 * r + c + s) & 255;
  endfunction

  function automatic logic [LW-1:0] exp_line(input int k, input int s,
      input bit tr, input int orow, input int ocol, input int oval);
    logic [LW-1:0] l;
    int r, c, v;
    l = '0;
    for (int i = 0; i < DIM; i++) begin
      r = tr ? i : k;
      c = tr ? k : i;
      v = (r == orow && c == ocol) ? oval : fval(r, c, s);
      l[i*EW +: EW] = EW'(v);
    end
    return l;
  endfunction

  task automatic wr(input int r, input int c, input int v);
    valid_data_in  = 1'b1;
    row_addr       = AW'(r);
    col_addr       = AW'(c);
    matrix_element = EW'(v);
    tick();
  endtask

  // Even columns bottom-up, then odd columns; stops after n writes.
  task automatic fill(input int s, input bit tr, input int n,
                      output int pulses);
    int cnt;
    cnt = 0;
    pulses = 0;
    transpose_in = tr;
    for (int p = 0; p < 2; p++)
      for (int c = p; c < DIM; c += 2)
        for (int r = DIM - 1; r >= 0; r--)
          if (cnt < n) begin
            wr(r, c, fval(r, c, s));
            cnt++;
            if (dup_err || ovf_err) pulses++;
          end
    valid_data_in = 1'b0;
  endtask

  task automatic drain(input string nm, input int s, input bit tr,
      input int budget, input int orow, input int ocol, input int oval);
    int w;
    w = 0;
    ready_in = 1'b1;
    while (!valid_data_out && w < budget) begin
      tick();
      w++;
    end
    chk({nm, "_start"}, valid_data_out, 1);
    for (int k = 0; k < DIM; k++) begin
      chk({nm, "_data"}, line_data, exp_line(k, s, tr, orow, ocol, oval));
      chk({nm, "_idx"}, line_index, k);
      chk({nm, "_last"}, frame_last, (k == DIM - 1));
      tick();
    end
    chk({nm, "_end"}, valid_data_out, 0);
  endtask

  initial begin
    int p, nk, cyc, dupc, n;
    logic stall, hs;
    logic [LW-1:0] pdata;
    logic [AW-1:0] pidx;

    // Reset state
    tick();
    tick();
    chk("rst_wr", write_ready, 0);
    chk("rst_vout", valid_data_out, 0);
    chk("rst_line", line_data, 0);
    chk("rst_err", {dup_err, ovf_err, frame_last}, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_wr", write_ready, 1);

    // Normal fill, line 0 two cycles after last write
    ready_in = 1'b1;
    fill(0, 1'b0, DIM * DIM, p);
    chk("t1_pulses", p, 0);
    chk("t1_lat0", valid_data_out, 0);
    tick();
    chk("t1_lat1", valid_data_out, 0);
    tick();
    drain("t1", 0, 1'b0, 0, -1, -1, 0);

    // Transposed
    fill(0, 1'b1, DIM * DIM, p);
    chk("t2_pulses", p, 0);
    drain("t2", 0, 1'b1, 4, -1, -1, 0);

    // Random backpressure
    ready_in = 1'b0;
    fill(3, 1'b0, DIM * DIM, p);
    nk = 0;
    cyc = 0;
    stall = 1'b0;
    pdata = '0;
    pidx = '0;
    while (nk < DIM && cyc < 2000) begin
      if (stall) begin
        chk("t3_hold_data", line_data, pdata);
        chk("t3_hold_idx", line_index, pidx);
      end
      if (valid_data_out) begin
        chk("t3_data", line_data, exp_line(nk, 3, 1'b0, -1, -1, 0));
        chk("t3_idx", line_index, nk);
      end
      ready_in = 1'($urandom_range(0, 1));
      hs = valid_data_out && ready_in;
      stall = valid_data_out && !ready_in;
      pdata = line_data;
      pidx = line_index;
      tick();
      if (hs) nk++;
      cyc++;
    end
    chk("t3_count", nk, DIM);
    ready_in = 1'b0;
    tick();
    chk("t3_end", valid_data_out, 0);

    // Two matrices under full backpressure, then a dropped write
    fill(10, 1'b0, DIM * DIM, p);
    chk("t4_a_wr", write_ready, 1);
    fill(20, 1'b0, DIM * DIM, p);
    chk("t4_pulses", p, 0);
    chk("t4_stall", write_ready, 0);
    wr(0, 0, 255);
    valid_data_in = 1'b0;
    chk("t4_ovf", ovf_err, 1);
    tick();
    chk("t4_ovf_once", ovf_err, 0);
    chk("t4_still_stall", write_ready, 0);
    drain("t4a", 10, 1'b0, 0, -1, -1, 0);
    chk("t4_wr_rise", write_ready, 1);
    drain("t4b", 20, 1'b0, 1, -1, -1, 0);

    // Duplicate write
    transpose_in = 1'b0;
    dupc = 0;
    wr(3, 4, 8'h11);
    if (dup_err) dupc++;
    n = 1;
    for (int c = 0; c < DIM; c++)
      for (int r = 0; r < DIM; r++)
        if (!(r == 3 && c == 4) && !(r == DIM - 1 && c == DIM - 1)) begin
          wr(r, c, fval(r, c, 0));
          if (dup_err) dupc++;
          n++;
          if (n == 100) begin
            wr(3, 4, 8'h22);
            if (dup_err) dupc++;
          end
        end
    valid_data_in = 1'b0;
    tick();
    tick();
    tick();
    chk("t5_no_early", valid_data_out, 0);
    chk("t5_wr", write_ready, 1);
    wr(DIM - 1, DIM - 1, fval(DIM - 1, DIM - 1, 0));
    valid_data_in = 1'b0;
    chk("t5_dupc", dupc, 1);
    drain("t5", 0, 1'b0, 3, 3, 4, 8'h22);

    // Reset mid-fill and mid-drain
    fill(50, 1'b0, 500, p);
    rst = 1'b1;
    tick();
    chk("t6_rst_wr", write_ready, 0);
    chk("t6_rst_vout", valid_data_out, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_wr", write_ready, 1);
    fill(60, 1'b0, DIM * DIM, p);
    chk("t6_pulses", p, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_mid", valid_data_out, 1);
    rst = 1'b1;
    tick();
    chk("t6_rst2_vout", valid_data_out, 0);
    chk("t6_rst2_line", line_data, 0);
    chk("t6_rst2_misc", {write_ready, frame_last, line_index}, 0);
    rst = 1'b0;
    tick();
    chk("t6_wr2", write_ready, 1);
    tick();
    tick();
    chk("t6_discard", valid_data_out, 0);
    fill(70, 1'b0, DIM * DIM, p);
    chk("t6_pulses2", p, 0);
    drain("t6", 70, 1'b0, 3, -1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_frame_buffer.md
# matrix_frame_buffer

Parametrised ping-pong buffer that collects a DIM x DIM matrix of ELEM_W-bit elements, written in any order by (row, col) address, and streams the completed matrix as DIM packed lines of DIM*ELEM_W bits under a valid/ready handshake. It generalises the fixed 32x32 x 8-bit matrix compiler. New over that block: configurable geometry, two banks so the next matrix can fill while the previous one drains, per-matrix transpose mode, output backpressure and error flags. It sits between the element producer and the serialiser / Ethernet framing stage.

## Interface
- DIM, 32, matrix rows = columns (2..64)
- ELEM_W, 8, bits per element
- ADDR_W, $clog2(DIM), row/col address width
- clk  in  1  single clock for the whole block
- rst  in  1  synchronous, active-high reset
- valid_data_in  in  1  element write strobe
- row_addr  in  ADDR_W  element row
- col_addr  in  ADDR_W  element column
- matrix_element  in  ELEM_W  element value
- transpose_in  in  1  line-order mode, sampled when a bank completes
- write_ready  out  1  a fill bank is available; writes accepted
- line_data  out  DIM*ELEM_W  packed output line
- line_index  out  ADDR_W  index of the current line
- valid_data_out  out  1  line_data valid
- ready_in  in  1  downstream accepts line
- frame_last  out  1  high with the final line of a matrix
- dup_err  out  1  one-cycle pulse: element rewritten within a fill
- ovf_err  out  1  one-cycle pulse: write dropped (write_ready low or address >= DIM)

## Operation
- Two banks, each with DIM*DIM element storage, DIM*DIM-bit written bitmap, unique-write counter, state EMPTY / FILLING / FULL / DRAINING, and a latched transpose bit.
- Write pointer wb selects the fill bank. A write is accepted when valid_data_in && write_ready && row_addr < DIM && col_addr < DIM. Bank goes EMPTY->FILLING on its first accepted write.
- Accepted write stores the element. If its bitmap bit is clear, set the bit and increment the counter. If the bit is already set, overwrite the data, leave the counter unchanged and pulse dup_err.
- When the counter reaches DIM*DIM, the bank becomes FULL and latches transpose_in. If the other bank is EMPTY, wb toggles; otherwise write_ready falls until that bank is freed.
- Rejected write (write_ready low or address out of range): no state change, ovf_err pulses.
- Reader: when idle and a bank is FULL (the older one first if both are), it enters DRAINING and emits lines 0..DIM-1.
- Normal packing: line k bits [c*ELEM_W +: ELEM_W] = M[k][c].
- Transpose packing: line k bits [r*ELEM_W +: ELEM_W] = M[r][k].
- line_index = k. frame_last = 1 only when k = DIM-1.
- On the handshake of the last line, the bank is cleared (bitmap, counter) and returns to EMPTY.
- Reset: all banks EMPTY, bitmaps and counters cleared, wb = bank 0, any partial or draining matrix is discarded.

## Timing
- While rst is high, all outputs are 0, including write_ready. Registered outputs clear on the first edge with rst high.
- First cycle after rst falls: write_ready = 1.
- Write accepted at edge t. If it completes the bank, FULL is visible at t+1 and valid_data_out for line 0 is high at t+2 at the earliest (reader idle).
- Output line is registered. line_data, line_index and frame_last hold stable while valid_data_out && !ready_in.
- Handshake = valid_data_out && ready_in. The next line appears the following cycle, giving one line per cycle with ready_in held high.
- valid_data_out falls the cycle after the last-line handshake, unless the other bank is FULL. In that case line 0 of that bank follows with at most one idle cycle.
- write_ready rises the cycle after the stalled-for bank is freed.
- Simultaneous completion of the fill bank and final handshake of the other bank: both take effect. wb toggles to the freed bank and write_ready stays 1.
- dup_err and ovf_err are registered and high for exactly one cycle per offending write (the cycle after it).
- rst asserted mid-frame or mid-drain overrides all other activity that cycle.

## Test plan
- Fill order: even columns with rows 31..0, then odd columns (DIM=32, ELEM_W=8); element = (7*row+col) mod 256; ready_in=1, transpose_in=0 -> 32 consecutive lines; line r byte c = (7r+c) mod 256; frame_last only on line 31; line 0 two cycles after the last write; no error pulses.
- Same data with transpose_in=1 at completion -> line k byte r = (7r+k) mod 256.
- Random ready_in (50%) during a drain -> line_data and line_index are unchanged in every stalled cycle; all 32 lines are delivered in order, none duplicated.
- ready_in=0; write two full matrices -> write_ready falls the cycle after the 2nd completes; a 3rd-matrix write gives one ovf_err pulse and is dropped. Raise ready_in -> matrix A drains, then B drains, write_ready rises after A's last handshake.
- Write (3,4)=0x11, later (3,4)=0x22, plus all other 1023 elements -> one dup_err pulse; completion only after 1024 unique writes; line 3 byte 4 = 0x22.
- rst pulsed after 500 writes and again mid-drain -> outputs 0 during reset; write_ready = 1 the next cycle; a fresh full matrix drains correctly with no stale data.
